// File: rtl/ram_fifo_pkg.sv
// Shared types and default sizing for the RAM-backed FIFO controller.
// Pointers carry one extra wrap bit above the RAM address.
package ram_fifo_pkg;

    localparam int DATAWIDTH_DEF = 8;
    localparam int ADDRWIDTH_DEF = 3;
    localparam int AF_LEVEL_DEF  = 6;
    localparam int DEPTH         = 1 << ADDRWIDTH_DEF;

    typedef logic [ADDRWIDTH_DEF:0]   ptr_t;
    typedef logic [DATAWIDTH_DEF-1:0] data_t;

endpackage : ram_fifo_pkg

// File: rtl/ram_fifo_ptr.sv
// Wrap-bit pointer for the FIFO controller: clears on rst/clear, else advances on inc.
// The MSB toggles each time the address field rolls over.
module ram_fifo_ptr
    import ram_fifo_pkg::*;
#(
    parameter int W = $bits(ptr_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_r;

    // Pointer register: rst and clear both return to zero, natural rollover wraps.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr_r <= {W{1'b0}};
        end else if (inc) begin
            ptr_r <= ptr_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule : ram_fifo_ptr

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving port 1 of a flip-flop RAM.
// Status is derived from the registered wrap-bit pointers; port 2 of the RAM is parked.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int ADDRWIDTH = ADDRWIDTH_DEF,
    parameter int AF_LEVEL  = AF_LEVEL_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic [ADDRWIDTH:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 en_w1_n,
    output logic [ADDRWIDTH-1:0] addr_w1,
    output logic [DATAWIDTH-1:0] data_w1,
    output logic                 en_w2_n,
    output logic [ADDRWIDTH-1:0] addr_w2,
    output logic [DATAWIDTH-1:0] data_w2,
    output logic                 en_r1_n,
    output logic [ADDRWIDTH-1:0] addr_r1,
    input  logic [DATAWIDTH-1:0] data_r1,
    output logic                 en_r2_n,
    output logic [ADDRWIDTH-1:0] addr_r2
);

    localparam int FIFO_DEPTH = 1 << ADDRWIDTH;
    localparam logic [ADDRWIDTH:0] AF_LEVEL_C = (ADDRWIDTH + 1)'(AF_LEVEL);

    generate
        if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_af_level_bad
            $error("ram_fifo_ctrl: AF_LEVEL must lie in 1..2**ADDRWIDTH");
        end
    endgenerate

    logic [ADDRWIDTH:0] wr_ptr_s;
    logic [ADDRWIDTH:0] rd_ptr_s;
    logic [ADDRWIDTH:0] count_s;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               clear_s;

    assign clear_s = rst | flush;
    assign count_s = wr_ptr_s - rd_ptr_s;
    assign empty_s = (wr_ptr_s == rd_ptr_s);
    assign full_s  = (wr_ptr_s[ADDRWIDTH-1:0] == rd_ptr_s[ADDRWIDTH-1:0]) &&
                     (wr_ptr_s[ADDRWIDTH] != rd_ptr_s[ADDRWIDTH]);

    // Transactions coinciding with rst/flush are dropped so the RAM is not touched.
    assign push_s = in_valid  & ~full_s  & ~clear_s;
    assign pop_s  = out_ready & ~empty_s & ~clear_s;

    ram_fifo_ptr #(.W(ADDRWIDTH + 1)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (push_s),
        .ptr   (wr_ptr_s)
    );

    ram_fifo_ptr #(.W(ADDRWIDTH + 1)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (pop_s),
        .ptr   (rd_ptr_s)
    );

    // Status and handshake outputs, all functions of the registered pointers.
    always_comb begin
        count       = count_s;
        full        = full_s;
        empty       = empty_s;
        almost_full = (count_s >= AF_LEVEL_C);
        in_ready    = ~full_s;
        out_valid   = ~empty_s;
        out_data    = data_r1;
    end

    // RAM port 1 write in the push cycle; read addresses the head whenever data is held.
    always_comb begin
        en_w1_n = 1'b1;
        addr_w1 = {ADDRWIDTH{1'b0}};
        data_w1 = {DATAWIDTH{1'b0}};
        if (push_s) begin
            en_w1_n = 1'b0;
            addr_w1 = wr_ptr_s[ADDRWIDTH-1:0];
            data_w1 = in_data;
        end else begin
            en_w1_n = 1'b1;
        end
        en_r1_n = empty_s;
        addr_r1 = rd_ptr_s[ADDRWIDTH-1:0];
    end

    // Port 2 is unused by the FIFO and held idle.
    always_comb begin
        en_w2_n = 1'b1;
        addr_w2 = {ADDRWIDTH{1'b0}};
        data_w2 = {DATAWIDTH{1'b0}};
        en_r2_n = 1'b1;
        addr_r2 = {ADDRWIDTH{1'b0}};
    end

endmodule : ram_fifo_ctrl

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural flip-flop RAM and a queue reference model.
module tb_ram_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       en_w1_n;
    logic [2:0] addr_w1;
    logic [7:0] data_w1;
    logic       en_w2_n;
    logic [2:0] addr_w2;
    logic [7:0] data_w2;
    logic       en_r1_n;
    logic [2:0] addr_r1;
    logic [7:0] data_r1;
    logic       en_r2_n;
    logic [2:0] addr_r2;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mq[$];
    logic [7:0]  exp_q[$];
    logic        chk_en   = 1'b0;
    logic        has_head = 1'b0;
    logic [7:0]  exp_head = 8'h00;
    logic [12:0] exp_stat = 13'h0;

    ram_fifo_ctrl #(.DATAWIDTH(8), .ADDRWIDTH(3), .AF_LEVEL(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .en_w1_n(en_w1_n), .addr_w1(addr_w1), .data_w1(data_w1),
        .en_w2_n(en_w2_n), .addr_w2(addr_w2), .data_w2(data_w2),
        .en_r1_n(en_r1_n), .addr_r1(addr_r1), .data_r1(data_r1),
        .en_r2_n(en_r2_n), .addr_r2(addr_r2)
    );

    // Flip-flop RAM: synchronous write, combinational read.
    logic [7:0] mem [8];
    always @(posedge clk) begin
        if (en_w1_n === 1'b0) mem[addr_w1] <= data_w1;
    end
    assign data_r1 = (en_r1_n === 1'b0) ? mem[addr_r1] : 8'h00;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // One clock of stimulus; the model expectations describe the state seen during this cycle.
    task automatic cycle(input logic r, input logic fl, input logic iv,
                         input logic [7:0] d, input logic ordy);
        int   n;
        logic pu;
        logic po;
        @(negedge clk);
        rst = r; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        n  = mq.size();
        pu = iv && (n < 8) && !r && !fl;
        po = ordy && (n > 0) && !r && !fl;
        exp_stat = {4'(n), n == 8, n == 0, n >= 6, n != 8, n != 0, !pu, n == 0, 1'b1, 1'b1};
        has_head = (n > 0);
        exp_head = (n > 0) ? mq[0] : 8'h00;
        chk_en   = !r;
        if (po) exp_q.push_back(mq.pop_front());
        if (pu) mq.push_back(d);
        if (r || fl) mq.delete();
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on each DUT handshake.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (chk_en) begin
                checks++;
                if ({count, full, empty, almost_full, in_ready, out_valid, en_w1_n, en_r1_n,
                     en_w2_n, en_r2_n} !== exp_stat) begin
                    errors++;
                    $display("FAIL status cnt/full/empty/af/in_rdy/out_vld/en_w1_n/en_r1_n/en_w2_n/en_r2_n got %b_%b%b%b%b%b%b%b%b%b want %b at %0t",
                             count, full, empty, almost_full, in_ready, out_valid, en_w1_n,
                             en_r1_n, en_w2_n, en_r2_n, exp_stat, $time);
                end
                if (has_head) begin
                    checks++;
                    if (out_data !== exp_head) begin
                        errors++;
                        $display("FAIL head out_data got %h want %h at %0t", out_data, exp_head, $time);
                    end
                end
                if (out_valid === 1'b1 && out_ready && !flush) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pop unexpected handshake got %h want none at %0t", out_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e) begin
                            errors++;
                            $display("FAIL pop out_data got %h want %h at %0t", out_data, e, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        // Reset
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        // Fill to full, then hold off an extra push
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 8'hA1 + 8'(i), 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        // Drain
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        // Steady state push+pop at count 3
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'hB0 + 8'(i), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 8'hC0 + 8'(i), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        // Push into empty: visible one cycle later
        cycle(1'b0, 1'b0, 1'b1, 8'h5C, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        // Flush with count 5 while pushing and popping
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'hD0 + 8'(i), 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        // Random traffic: push-heavy then pop-heavy, with rare flushes
        for (int i = 0; i < 400; i++) begin
            logic iv;
            logic ordy;
            logic fl;
            iv   = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            ordy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 39) == 0);
            cycle(1'b0, fl, iv, 8'($urandom), ordy);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover entries got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram_fifo_ctrl
